// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC, single-outstanding imem requests and a small instruction queue.
// Defining FETCH_MISALIGN_TRAP_EN makes misaligned redirects trap instead of being silently aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        misalign
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        DRAIN  = 3'd3,
`ifdef FETCH_MISALIGN_TRAP_EN
        HALTED = 3'd4,
        TRAP   = 3'd5
`else
        HALTED = 3'd4
`endif
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t           state_r;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      req_pc_r;
    logic             out_r;
    logic             imem_req_r;
    logic [31:0]      imem_addr_r;
    logic [31:0]      ir_r;
    logic [31:0]      ir_pc_r;
    logic             ir_valid_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      q_data_r [QUEUE_DEPTH];
    logic [31:0]      q_pc_r   [QUEUE_DEPTH];

    logic [31:0]      redir_pc_s;
    logic             granted_s;
    logic             flush_s;
    logic             push_s;
    logic             pop_s;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [31:0]      ir_nxt_s;
    logic [31:0]      ir_pc_nxt_s;
    logic [31:0]      fetch_pc_nxt_s;
    logic             issue_s;
    logic             req_nxt_s;
    logic [31:0]      addr_nxt_s;
    logic             out_nxt_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             redir_bad_s;
    logic             misalign_r;

    // Misaligned redirect detection.
    always_comb begin
        redir_bad_s = (redirect_pc[1:0] != 2'b00);
    end

    assign misalign = misalign_r;
`else
    assign misalign = 1'b0;
`endif

    // Redirect target; only consumed when aligned or in the aligning build.
    always_comb begin
        redir_pc_s = word_align(redirect_pc);
    end

    // FSM next state and queue push/pop/flush decode; redirect overrides everything.
    always_comb begin
        granted_s   = imem_req_r && imem_gnt;
        flush_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        state_nxt_s = state_r;
        if (redirect_valid) begin
            flush_s = 1'b1;
            if ((out_r && !imem_rvalid) || granted_s) begin
                state_nxt_s = DRAIN;
            end else begin
                state_nxt_s = REQ;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            state_nxt_s = redir_bad_s ? TRAP : state_nxt_s;
`endif
        end else begin
            pop_s = ir_valid_r && ir_ready;
            case (state_r)
                IDLE: begin
                    state_nxt_s = REQ;
                end
                REQ: begin
                    // A pending request is held through halt; only an idle REQ parks.
                    if (granted_s) begin
                        state_nxt_s = WAIT;
                    end else if (!imem_req_r && halt) begin
                        state_nxt_s = HALTED;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push_s      = 1'b1;
                        state_nxt_s = halt ? HALTED : REQ;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                DRAIN: begin
                    state_nxt_s = imem_rvalid ? REQ : DRAIN;
                end
                HALTED: begin
                    state_nxt_s = halt ? HALTED : REQ;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                TRAP: begin
                    state_nxt_s = TRAP;
                end
`endif
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Queue pointers, occupancy and the word that becomes the head next cycle.
    always_comb begin
        if (flush_s) begin
            count_nxt_s = CNT_ZERO;
            head_nxt_s  = PTR_ZERO;
            tail_nxt_s  = PTR_ZERO;
        end else begin
            head_nxt_s = pop_s  ? (head_r + PTR_ONE) : head_r;
            tail_nxt_s = push_s ? (tail_r + PTR_ONE) : tail_r;
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
        // A push into a queue that is empty after the pop bypasses storage.
        if (count_nxt_s == CNT_ZERO) begin
            ir_nxt_s    = ir_r;
            ir_pc_nxt_s = ir_pc_r;
        end else if (push_s && (head_nxt_s == tail_r)) begin
            ir_nxt_s    = imem_rdata;
            ir_pc_nxt_s = req_pc_r;
        end else begin
            ir_nxt_s    = q_data_r[head_nxt_s];
            ir_pc_nxt_s = q_pc_r[head_nxt_s];
        end
    end

    // Fetch PC advance, request issue/hold and outstanding-response tracking.
    always_comb begin
        if (redirect_valid) begin
            fetch_pc_nxt_s = redir_pc_s;
        end else if (granted_s) begin
            fetch_pc_nxt_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
        issue_s = (state_nxt_s == REQ) && (count_nxt_s < DEPTH_C) && !halt;
        if ((state_nxt_s == REQ) && imem_req_r && !granted_s && !redirect_valid) begin
            req_nxt_s  = 1'b1;
            addr_nxt_s = imem_addr_r;
        end else if (issue_s) begin
            req_nxt_s  = 1'b1;
            addr_nxt_s = fetch_pc_nxt_s;
        end else begin
            req_nxt_s  = 1'b0;
            addr_nxt_s = imem_addr_r;
        end
        if (granted_s) begin
            out_nxt_s = 1'b1;
        end else if (imem_rvalid) begin
            out_nxt_s = 1'b0;
        end else begin
            out_nxt_s = out_r;
        end
    end

    // FSM, request, queue storage and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC;
            req_pc_r    <= RESET_PC;
            out_r       <= 1'b0;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
            ir_r        <= 32'd0;
            ir_pc_r     <= 32'd0;
            ir_valid_r  <= 1'b0;
            head_r      <= PTR_ZERO;
            tail_r      <= PTR_ZERO;
            count_r     <= CNT_ZERO;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_r  <= 1'b0;
`endif
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_data_r[i] <= 32'd0;
                q_pc_r[i]   <= 32'd0;
            end
        end else begin
            state_r     <= state_nxt_s;
            fetch_pc_r  <= fetch_pc_nxt_s;
            out_r       <= out_nxt_s;
            imem_req_r  <= req_nxt_s;
            imem_addr_r <= addr_nxt_s;
            ir_r        <= ir_nxt_s;
            ir_pc_r     <= ir_pc_nxt_s;
            ir_valid_r  <= (count_nxt_s != CNT_ZERO);
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            count_r     <= count_nxt_s;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_r  <= redirect_valid ? redir_bad_s : misalign_r;
`endif
            if (granted_s) begin
                req_pc_r <= imem_addr_r;
            end
            if (push_s) begin
                q_data_r[tail_r] <= imem_rdata;
                q_pc_r[tail_r]   <= req_pc_r;
            end
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign ir        = ir_r;
    assign ir_pc     = ir_pc_r;
    assign ir_valid  = ir_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, halt, reset and misaligned redirects.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        misalign;

    int          checks = 0;
    int          failures = 0;
    int          mem_lat = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          lat_cnt = 0;
    int          cyc = 0;
    int          gnt_count = 0;
    int          c0 = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory sees the grant presented before the edge, outputs are sampled 1ns after it.
    task automatic step();
        logic        granted;
        logic [31:0] gaddr;
        granted = imem_req && imem_gnt;
        gaddr   = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (granted) begin
            pend      = 1'b1;
            pend_addr = gaddr;
            lat_cnt   = mem_lat;
            gnt_count++;
        end
        if (pend) begin
            if (lat_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(pend_addr);
                pend        = 1'b0;
            end else begin
                lat_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
        imem_gnt       = 1'b0;
        ir_ready       = 1'b0;
        pend           = 1'b0;
        imem_rvalid    = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        gnt_count = 0;
    endtask

    task automatic wait_valid(input string tag, input int budget, input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!ir_valid && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, {31'd0, ir_valid}, 32'd1);
        check({tag, "_pc"}, ir_pc, exp_pc);
        check({tag, "_ir"}, ir, word_of(exp_pc));
    endtask

    initial begin
        // Reset values, then zero-wait streaming with a always-ready decoder.
        imem_gnt = 1'b1;
        ir_ready = 1'b1;
        mem_lat  = 1;
        step();
        step();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0000_0000);
        check("rst_ir", ir, 32'd0);
        check("rst_ir_pc", ir_pc, 32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;
        step();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        wait_valid("stream0", 8, 32'h0);
        c0 = cyc;
        step();
        wait_valid("stream4", 8, 32'h4);
        check("stream_gap1", cyc - c0, 32'd2);
        c0 = cyc;
        step();
        wait_valid("stream8", 8, 32'h8);
        check("stream_gap2", cyc - c0, 32'd2);

        // Backpressure: two words fill the queue, one pop lets one request out.
        do_reset();
        imem_gnt = 1'b1;
        mem_lat  = 1;
        for (int i = 0; i < 10; i++) step();
        check("bp_grants", gnt_count, 32'd2);
        check("bp_req_idle", {31'd0, imem_req}, 32'd0);
        check("bp_valid", {31'd0, ir_valid}, 32'd1);
        check("bp_head_pc", ir_pc, 32'h0);
        check("bp_head_ir", ir, word_of(32'h0));
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        check("bp_pop_pc", ir_pc, 32'h4);
        check("bp_reissue_req", {31'd0, imem_req}, 32'd1);
        check("bp_reissue_addr", imem_addr, 32'h8);
        for (int i = 0; i < 6; i++) step();
        check("bp_grants2", gnt_count, 32'd3);
        check("bp_req_idle2", {31'd0, imem_req}, 32'd0);
        check("bp_head_pc2", ir_pc, 32'h4);

        // Redirect while a slow response is outstanding: stale word is drained.
        do_reset();
        imem_gnt = 1'b1;
        ir_ready = 1'b1;
        mem_lat  = 3;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("redir_valid_clr", {31'd0, ir_valid}, 32'd0);
        check("redir_drain_noreq", {31'd0, imem_req}, 32'd0);
        step();
        step();
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_stale_dropped", {31'd0, ir_valid}, 32'd0);
        wait_valid("redir", 12, 32'h0000_0100);

        // Halt with an un-granted request: held, answered, then fetch stops until release.
        do_reset();
        ir_ready = 1'b1;
        mem_lat  = 1;
        step();
        halt = 1'b1;
        step();
        step();
        step();
        check("halt_hold_req", {31'd0, imem_req}, 32'd1);
        check("halt_hold_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        check("halt_granted_req", {31'd0, imem_req}, 32'd0);
        step();
        check("halt_push_valid", {31'd0, ir_valid}, 32'd1);
        check("halt_push_pc", ir_pc, 32'h0);
        for (int i = 0; i < 4; i++) step();
        check("halt_no_req", {31'd0, imem_req}, 32'd0);
        check("halt_grants", gnt_count, 32'd1);
        halt = 1'b0;
        step();
        check("halt_resume_req", {31'd0, imem_req}, 32'd1);
        check("halt_resume_addr", imem_addr, 32'h4);
        wait_valid("halt_resume", 8, 32'h4);

        // Redirect withdraws an un-granted request and reissues at the target.
        do_reset();
        ir_ready = 1'b1;
        mem_lat  = 1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        check("withdraw_req", {31'd0, imem_req}, 32'd1);
        check("withdraw_addr", imem_addr, 32'h0000_0040);
        step();
        check("withdraw_stable", imem_addr, 32'h0000_0040);
        imem_gnt = 1'b1;
        wait_valid("withdraw", 8, 32'h0000_0040);

        // Misaligned redirect handling.
        do_reset();
        ir_ready = 1'b1;
        mem_lat  = 1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_misalign", {31'd0, misalign}, 32'd1);
        check("trap_noreq", {31'd0, imem_req}, 32'd0);
        imem_gnt = 1'b1;
        step();
        step();
        step();
        check("trap_stays_noreq", {31'd0, imem_req}, 32'd0);
        check("trap_stays_misalign", {31'd0, misalign}, 32'd1);
        check("trap_no_valid", {31'd0, ir_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("trap_exit_misalign", {31'd0, misalign}, 32'd0);
        check("trap_exit_req", {31'd0, imem_req}, 32'd1);
        check("trap_exit_addr", imem_addr, 32'h0000_0200);
        wait_valid("trap_exit", 8, 32'h0000_0200);
`else
        check("align_misalign", {31'd0, misalign}, 32'd0);
        check("align_req", {31'd0, imem_req}, 32'd1);
        check("align_addr", imem_addr, 32'h0000_0100);
        imem_gnt = 1'b1;
        wait_valid("align", 8, 32'h0000_0100);
`endif

        // Reset mid-request: outputs clear at once and the late response is ignored.
        do_reset();
        ir_ready = 1'b1;
        mem_lat  = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        step();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", imem_addr, 32'h0);
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_valid", {31'd0, ir_valid}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("late_rvalid_ignored", {31'd0, ir_valid}, 32'd0);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        wait_valid("post_rst", 12, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
